tetron_kick_shaper: RTL and testbench

Parametrised successor to the per-piece tetromino shapers. A single block serves all seven pieces (I, O, T, S, Z, J, L) and holds the active piece's identity and rotation. It runs rotation requests as a multi-cycle handshake with the collision checker, offering wall-kick candidates one at a time until one is accepted or the list is exhausted. It sits between game control (spawn and rotate commands) and the board collision checker and renderer, which consume the committed block offsets.

---
 rtl/tetron_pkg.sv | 87 ++++++++
 rtl/tetron_kick_shaper_rot_lut.sv | 38 +++
 rtl/tetron_kick_shaper.sv | 198 +++++++++++++++++++
 tb/tb_tetron_kick_shaper.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetron_pkg.sv
// tetron_pkg: shared piece, state, offset and kick definitions
// for the tetromino kick shaper.
package tetron_pkg;

   typedef enum logic [2:0] {
      P_I    = 3'd0,
      P_O    = 3'd1,
      P_T    = 3'd2,
      P_S    = 3'd3,
      P_Z    = 3'd4,
      P_J    = 3'd5,
      P_L    = 3'd6,
      P_NONE = 3'd7
   } piece_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PROPOSE = 2'd1,
      S_COMMIT  = 2'd2
   } state_e;

   localparam int MAX_KICKS = 5;

   // One (v,h) pair as {v[3:0], h[3:0]}, both signed
   function automatic logic [7:0] vh(
      input int v,
      input int h
   );
      return {4'(v), 4'(h)};
   endfunction

   // Rotation-0 offsets of blocks 4..2 packed high to low;
   // block 1 is always (0,0) and is not stored
   function automatic logic [23:0] base_tab(
      input logic [2:0] p
   );
      logic [23:0] t;
      t = '0;
      case (p)
         P_I:     t = {vh(0, 2),  vh(0, 1),  vh(0, -1)};
         P_O:     t = {vh(1, 1),  vh(1, 0),  vh(0, 1)};
         P_T:     t = {vh(1, 0),  vh(0, 1),  vh(0, -1)};
         P_S:     t = {vh(1, 0),  vh(1, -1), vh(0, 1)};
         P_Z:     t = {vh(1, 1),  vh(1, 0),  vh(0, -1)};
         P_J:     t = {vh(1, 1),  vh(0, 1),  vh(0, -1)};
         P_L:     t = {vh(1, -1), vh(0, 1),  vh(0, -1)};
         default: t = '0;
      endcase
      return t;
   endfunction

   // Wall-kick horizontal shift for candidate k
   function automatic logic signed [3:0] kick_val(
      input logic [2:0] k
   );
      logic signed [3:0] r;
      case (k)
         3'd0:    r = 4'sd0;
         3'd1:    r = -4'sd1;
         3'd2:    r = 4'sd1;
         3'd3:    r = -4'sd2;
         3'd4:    r = 4'sd2;
         default: r = 4'sd0;
      endcase
      return r;
   endfunction

   // Clockwise quarter-turn (v,h) -> (h,-v), applied r times
   function automatic logic [7:0] rot_vh(
      input logic [7:0] p,
      input logic [1:0] r
   );
      logic signed [3:0] v;
      logic signed [3:0] h;
      logic [7:0]        o;
      v = signed'(p[7:4]);
      h = signed'(p[3:0]);
      case (r)
         2'd0:    o = {v, h};
         2'd1:    o = {h, -v};
         2'd2:    o = {-v, -h};
         default: o = {-h, v};
      endcase
      return o;
   endfunction

endpackage

// File: rtl/tetron_kick_shaper_rot_lut.sv
// tetron_rot_lut: combinational (piece, rotation, kick) to
// four packed (v,h) block offsets. O ignores rotation.
module tetron_rot_lut
   import tetron_pkg::*;
#(
   parameter int OFS_W = 5
) (
   input  logic [2:0]         i_piece,
   input  logic [1:0]         i_rot,
   input  logic [OFS_W-1:0]   i_kick,
   output logic [4*OFS_W-1:0] o_voff,
   output logic [4*OFS_W-1:0] o_hoff
);

   logic [23:0] w_tab;

   assign w_tab = base_tab(i_piece);

   // Rotate each stored block, widen it and apply the kick
   always_comb begin
      logic [7:0] pr;
      pr     = '0;
      o_voff = '0;
      o_hoff = '0;
      o_hoff[OFS_W-1:0] = i_kick;
      for (int b = 0; b < 3; b++) begin
         if (i_piece == P_O)
            pr = w_tab[b*8 +: 8];
         else
            pr = rot_vh(w_tab[b*8 +: 8], i_rot);
         o_voff[(b+1)*OFS_W +: OFS_W] =
            OFS_W'(signed'(pr[7:4]));
         o_hoff[(b+1)*OFS_W +: OFS_W] =
            OFS_W'(signed'(pr[3:0])) + i_kick;
      end
   end

endmodule

// File: rtl/tetron_kick_shaper.sv
// tetron_kick_shaper: active piece state plus rotation handshake
// with wall kicks. Optional macro: TETRON_WALL_KICK_EN.
module tetron_kick_shaper
   import tetron_pkg::*;
#(
   parameter int OFS_W = 5,
   parameter int KICKS = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               active,
   input  logic               spawn,
   input  logic [2:0]         piece_id,
   input  logic               rot_req,
   input  logic               rot_dir,
   output logic               cand_valid,
   output logic [4*OFS_W-1:0] cand_voff,
   output logic [4*OFS_W-1:0] cand_hoff,
   input  logic               chk_done,
   input  logic               chk_ok,
   output logic [4*OFS_W-1:0] blk_voff,
   output logic [4*OFS_W-1:0] blk_hoff,
   output logic [1:0]         rotation,
   output logic [OFS_W-1:0]   kick_h,
   output logic               busy,
   output logic               rot_done,
   output logic               rot_ok
);

`ifdef TETRON_WALL_KICK_EN
   localparam int KN = KICKS;
`else
   localparam int KN = 1;
`endif
   localparam logic [2:0] KLAST = 3'(KN - 1);

   state_e             r_state;
   logic [2:0]         r_piece;
   logic               r_valid;
   logic [1:0]         r_rot;
   logic [1:0]         r_pend;
   logic [2:0]         r_k;
   logic [OFS_W-1:0]   r_kick;
   logic               r_cand_v;
   logic [4*OFS_W-1:0] r_cand_voff;
   logic [4*OFS_W-1:0] r_cand_hoff;
   logic [4*OFS_W-1:0] r_blk_voff;
   logic [4*OFS_W-1:0] r_blk_hoff;
   logic               r_done;
   logic               r_ok;

   logic               w_spawn;
   logic               w_req;
   logic [1:0]         w_new_rot;
   logic [OFS_W-1:0]   w_kick_nxt;
   logic [OFS_W-1:0]   w_kick_cur;
   logic [2:0]         w_lut_piece;
   logic [1:0]         w_lut_rot;
   logic [OFS_W-1:0]   w_lut_kick;
   logic [4*OFS_W-1:0] w_lut_voff;
   logic [4*OFS_W-1:0] w_lut_hoff;

   assign w_spawn   = spawn && (piece_id != P_NONE);
   assign w_req     = rot_req && active && r_valid &&
                      (r_state != S_PROPOSE) && !w_spawn;
   assign w_new_rot = rot_dir ? r_rot - 2'd1 : r_rot + 2'd1;

`ifdef TETRON_WALL_KICK_EN
   logic [2:0] w_k_nxt;
   assign w_k_nxt    = r_k + 3'd1;
   assign w_kick_nxt = r_kick + OFS_W'(kick_val(w_k_nxt));
   assign w_kick_cur = r_kick + OFS_W'(kick_val(r_k));
`else
   assign w_kick_nxt = '0;
   assign w_kick_cur = '0;
`endif

   // Shared LUT input: spawn shape, first candidate or next candidate
   always_comb begin
      w_lut_piece = r_piece;
      w_lut_rot   = r_pend;
      w_lut_kick  = w_kick_nxt;
      if (w_spawn) begin
         w_lut_piece = piece_id;
         w_lut_rot   = 2'd0;
         w_lut_kick  = '0;
      end else if (w_req) begin
         w_lut_rot   = w_new_rot;
         w_lut_kick  = r_kick;
      end
   end

   tetron_rot_lut #(
      .OFS_W (OFS_W)
   ) u_lut (
      .i_piece (w_lut_piece),
      .i_rot   (w_lut_rot),
      .i_kick  (w_lut_kick),
      .o_voff  (w_lut_voff),
      .o_hoff  (w_lut_hoff)
   );

   // Rotation FSM with registered candidate and committed state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_piece     <= P_NONE;
         r_valid     <= 1'b0;
         r_rot       <= 2'd0;
         r_pend      <= 2'd0;
         r_k         <= 3'd0;
         r_kick      <= '0;
         r_cand_v    <= 1'b0;
         r_cand_voff <= '0;
         r_cand_hoff <= '0;
         r_blk_voff  <= '0;
         r_blk_hoff  <= '0;
         r_done      <= 1'b0;
         r_ok        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_ok   <= 1'b0;
         if (w_spawn) begin
            r_state    <= S_IDLE;
            r_piece    <= piece_id;
            r_valid    <= 1'b1;
            r_rot      <= 2'd0;
            r_k        <= 3'd0;
            r_kick     <= '0;
            r_cand_v   <= 1'b0;
            r_blk_voff <= w_lut_voff;
            r_blk_hoff <= w_lut_hoff;
         end else if (!active) begin
            r_state  <= S_IDLE;
            r_k      <= 3'd0;
            r_cand_v <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_COMMIT: begin
                  r_state <= S_IDLE;
                  if (w_req) begin
                     r_state     <= S_PROPOSE;
                     r_pend      <= w_new_rot;
                     r_k         <= 3'd0;
                     r_cand_v    <= 1'b1;
                     r_cand_voff <= w_lut_voff;
                     r_cand_hoff <= w_lut_hoff;
                  end
               end
               S_PROPOSE: begin
                  if (chk_done) begin
                     if (chk_ok) begin
                        r_state    <= S_COMMIT;
                        r_rot      <= r_pend;
                        r_kick     <= w_kick_cur;
                        r_blk_voff <= r_cand_voff;
                        r_blk_hoff <= r_cand_hoff;
                        r_cand_v   <= 1'b0;
                        r_done     <= 1'b1;
                        r_ok       <= 1'b1;
                     end else if (r_k < KLAST) begin
                        r_k         <= r_k + 3'd1;
                        r_cand_voff <= w_lut_voff;
                        r_cand_hoff <= w_lut_hoff;
                     end else begin
                        r_state  <= S_IDLE;
                        r_k      <= 3'd0;
                        r_cand_v <= 1'b0;
                        r_done   <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_cand_v <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cand_valid = r_cand_v && active;
   assign cand_voff  = active ? r_cand_voff : '0;
   assign cand_hoff  = active ? r_cand_hoff : '0;
   assign blk_voff   = active ? r_blk_voff : '0;
   assign blk_hoff   = active ? r_blk_hoff : '0;
   assign rotation   = active ? r_rot : 2'd0;
   assign busy       = (r_state == S_PROPOSE) && active;
   assign rot_done   = r_done && active;
   assign rot_ok     = r_ok && active;

`ifdef TETRON_WALL_KICK_EN
   assign kick_h = active ? r_kick : '0;
`else
   assign kick_h = '0;
`endif

endmodule

// File: tb/tb_tetron_kick_shaper.sv
// tb_tetron_kick_shaper: directed checks of spawn, rotation,
// kicks, abort, illegal spawn, active gating and O symmetry.
module tb_tetron_kick_shaper;

   localparam int W = 5;

`ifdef TETRON_WALL_KICK_EN
   localparam int NK = 5;
`else
   localparam int NK = 1;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           active;
   logic           spawn;
   logic [2:0]     piece_id;
   logic           rot_req;
   logic           rot_dir;
   logic           cand_valid;
   logic [4*W-1:0] cand_voff;
   logic [4*W-1:0] cand_hoff;
   logic           chk_done;
   logic           chk_ok;
   logic [4*W-1:0] blk_voff;
   logic [4*W-1:0] blk_hoff;
   logic [1:0]     rotation;
   logic [W-1:0]   kick_h;
   logic           busy;
   logic           rot_done;
   logic           rot_ok;

   int checks = 0;
   int errors = 0;
   int kt[5] = '{0, -1, 1, -2, 2};

   always #5 clk = ~clk;

   tetron_kick_shaper #(.OFS_W(W), .KICKS(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .active     (active),
      .spawn      (spawn),
      .piece_id   (piece_id),
      .rot_req    (rot_req),
      .rot_dir    (rot_dir),
      .cand_valid (cand_valid),
      .cand_voff  (cand_voff),
      .cand_hoff  (cand_hoff),
      .chk_done   (chk_done),
      .chk_ok     (chk_ok),
      .blk_voff   (blk_voff),
      .blk_hoff   (blk_hoff),
      .rotation   (rotation),
      .kick_h     (kick_h),
      .busy       (busy),
      .rot_done   (rot_done),
      .rot_ok     (rot_ok)
   );

   // Pack blocks 4..1 (high to low) into one offset bus
   function automatic logic [4*W-1:0] pk(
      input int b4, input int b3, input int b2, input int b1
   );
      return {W'(b4), W'(b3), W'(b2), W'(b1)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_spawn(input logic [2:0] p);
      spawn = 1'b1; piece_id = p;
      step();
      spawn = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; active = 1'b1; spawn = 1'b0; piece_id = 3'd0;
      rot_req = 1'b0; rot_dir = 1'b0; chk_done = 1'b0; chk_ok = 1'b0;
      step(); step();
      rst = 1'b0;
      checks++; if (blk_voff !== '0) begin $display("FAIL reset_voff got %h want 0", blk_voff); errors++; end
      checks++; if (blk_hoff !== '0) begin $display("FAIL reset_hoff got %h want 0", blk_hoff); errors++; end
      checks++; if ({cand_valid, busy, rot_done, rot_ok, rotation, kick_h} !== '0) begin
         $display("FAIL reset_ctl got %b%b%b%b %h %h want 0", cand_valid, busy, rot_done, rot_ok, rotation, kick_h); errors++; end
      rot_req = 1'b1;
      step();
      rot_req = 1'b0;
      checks++; if (busy !== 1'b0) begin $display("FAIL req_before_spawn busy got %b want 0", busy); errors++; end
   endtask

   task automatic test_spawn_l();
      do_spawn(3'd6);
      checks++; if (blk_voff !== pk(1, 0, 0, 0)) begin $display("FAIL spawn_l_voff got %h want %h", blk_voff, pk(1, 0, 0, 0)); errors++; end
      checks++; if (blk_hoff !== pk(-1, 1, -1, 0)) begin $display("FAIL spawn_l_hoff got %h want %h", blk_hoff, pk(-1, 1, -1, 0)); errors++; end
      checks++; if (rotation !== 2'd0) begin $display("FAIL spawn_l_rot got %0d want 0", rotation); errors++; end
   endtask

   task automatic test_rotate_t();
      do_spawn(3'd2);
      rot_req = 1'b1; rot_dir = 1'b0;
      step();
      rot_req = 1'b0;
      checks++; if (cand_valid !== 1'b1 || busy !== 1'b1) begin $display("FAIL t_cand_valid got %b busy %b want 1 1", cand_valid, busy); errors++; end
      checks++; if (cand_voff !== pk(0, 1, -1, 0) || cand_hoff !== pk(-1, 0, 0, 0)) begin
         $display("FAIL t_cand got %h %h want %h %h", cand_voff, cand_hoff, pk(0, 1, -1, 0), pk(-1, 0, 0, 0)); errors++; end
      step();
      chk_done = 1'b1; chk_ok = 1'b1;
      step();
      chk_done = 1'b0; chk_ok = 1'b0;
      checks++; if (rot_done !== 1'b1 || rot_ok !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL t_done got done %b ok %b busy %b want 1 1 0", rot_done, rot_ok, busy); errors++; end
      checks++; if (rotation !== 2'd1) begin $display("FAIL t_rot got %0d want 1", rotation); errors++; end
      checks++; if (blk_voff !== pk(0, 1, -1, 0) || blk_hoff !== pk(-1, 0, 0, 0)) begin
         $display("FAIL t_blk got %h %h want %h %h", blk_voff, blk_hoff, pk(0, 1, -1, 0), pk(-1, 0, 0, 0)); errors++; end
      step();
      checks++; if (rot_done !== 1'b0) begin $display("FAIL t_done_pulse got %b want 0", rot_done); errors++; end
   endtask

   task automatic test_kicks_i();
      do_spawn(3'd0);
      rot_req = 1'b1; rot_dir = 1'b0;
      step();
      rot_req = 1'b0;
      checks++; if (cand_voff !== pk(2, 1, -1, 0) || cand_hoff !== pk(0, 0, 0, 0)) begin
         $display("FAIL i_cand0 got %h %h want %h 0", cand_voff, cand_hoff, pk(2, 1, -1, 0)); errors++; end
      chk_done = 1'b1; chk_ok = 1'b0;
      step();
`ifdef TETRON_WALL_KICK_EN
      checks++; if (cand_valid !== 1'b1 || rot_done !== 1'b0 || cand_hoff !== pk(-1, -1, -1, -1)) begin
         $display("FAIL i_cand1 got v %b d %b h %h want 1 0 %h", cand_valid, rot_done, cand_hoff, pk(-1, -1, -1, -1)); errors++; end
      step();
      checks++; if (cand_hoff !== pk(1, 1, 1, 1)) begin $display("FAIL i_cand2 got %h want %h", cand_hoff, pk(1, 1, 1, 1)); errors++; end
      chk_ok = 1'b1;
      step();
      chk_done = 1'b0; chk_ok = 1'b0;
      checks++; if (rot_done !== 1'b1 || rot_ok !== 1'b1 || kick_h !== W'(1)) begin
         $display("FAIL i_commit got d %b ok %b kick %h want 1 1 01", rot_done, rot_ok, kick_h); errors++; end
      checks++; if (blk_hoff !== pk(1, 1, 1, 1) || blk_voff !== pk(2, 1, -1, 0) || rotation !== 2'd1) begin
         $display("FAIL i_blk got %h %h r%0d want %h %h r1", blk_voff, blk_hoff, rotation, pk(2, 1, -1, 0), pk(1, 1, 1, 1)); errors++; end
`else
      chk_done = 1'b0;
      checks++; if (rot_done !== 1'b1 || rot_ok !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL i_single got d %b ok %b busy %b want 1 0 0", rot_done, rot_ok, busy); errors++; end
      checks++; if (rotation !== 2'd0 || kick_h !== '0) begin
         $display("FAIL i_single_state got r%0d k %h want r0 k0", rotation, kick_h); errors++; end
`endif
      step();
   endtask

   task automatic test_exhaust();
      do_spawn(3'd0);
      rot_req = 1'b1; rot_dir = 1'b0;
      step();
      rot_req = 1'b0;
      chk_done = 1'b1; chk_ok = 1'b0;
      for (int i = 0; i < NK; i++) begin
         checks++; if (cand_valid !== 1'b1 || rot_done !== 1'b0 || cand_hoff !== pk(kt[i], kt[i], kt[i], kt[i])) begin
            $display("FAIL ex_cand%0d got v %b d %b h %h want 1 0 %h", i, cand_valid, rot_done, cand_hoff, pk(kt[i], kt[i], kt[i], kt[i])); errors++; end
         step();
      end
      chk_done = 1'b0;
      checks++; if (rot_done !== 1'b1 || rot_ok !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL ex_done got d %b ok %b busy %b want 1 0 0", rot_done, rot_ok, busy); errors++; end
      checks++; if (rotation !== 2'd0 || kick_h !== '0 || blk_voff !== '0 || blk_hoff !== pk(2, 1, -1, 0)) begin
         $display("FAIL ex_state got r%0d k %h %h %h want r0 k0 0 %h", rotation, kick_h, blk_voff, blk_hoff, pk(2, 1, -1, 0)); errors++; end
      step();
   endtask

   task automatic test_spawn_abort();
      do_spawn(3'd2);
      rot_req = 1'b1; rot_dir = 1'b0;
      step();
      rot_dir = 1'b1;
      step();
      rot_req = 1'b0;
      checks++; if (busy !== 1'b1 || cand_voff !== pk(0, 1, -1, 0)) begin
         $display("FAIL busy_req got busy %b cand %h want 1 %h", busy, cand_voff, pk(0, 1, -1, 0)); errors++; end
      do_spawn(3'd3);
      checks++; if (busy !== 1'b0 || rot_done !== 1'b0 || cand_valid !== 1'b0 || rotation !== 2'd0) begin
         $display("FAIL abort got busy %b d %b v %b r%0d want 0 0 0 r0", busy, rot_done, cand_valid, rotation); errors++; end
      checks++; if (blk_voff !== pk(1, 1, 0, 0) || blk_hoff !== pk(0, -1, 1, 0)) begin
         $display("FAIL abort_blk got %h %h want %h %h", blk_voff, blk_hoff, pk(1, 1, 0, 0), pk(0, -1, 1, 0)); errors++; end
      chk_done = 1'b1; chk_ok = 1'b1;
      step();
      chk_done = 1'b0; chk_ok = 1'b0;
      checks++; if (rot_done !== 1'b0 || rotation !== 2'd0) begin
         $display("FAIL chk_idle got d %b r%0d want 0 r0", rot_done, rotation); errors++; end
   endtask

   task automatic test_ccw_s();
      rot_req = 1'b1; rot_dir = 1'b1;
      step();
      rot_req = 1'b0;
      checks++; if (cand_voff !== pk(0, 1, -1, 0) || cand_hoff !== pk(1, 1, 0, 0)) begin
         $display("FAIL s_ccw_cand got %h %h want %h %h", cand_voff, cand_hoff, pk(0, 1, -1, 0), pk(1, 1, 0, 0)); errors++; end
      chk_done = 1'b1; chk_ok = 1'b1;
      step();
      chk_done = 1'b0; chk_ok = 1'b0;
      checks++; if (rot_done !== 1'b1 || rot_ok !== 1'b1 || rotation !== 2'd3) begin
         $display("FAIL s_ccw_done got d %b ok %b r%0d want 1 1 r3", rot_done, rot_ok, rotation); errors++; end
      step();
   endtask

   task automatic test_illegal_active();
      do_spawn(3'd7);
      checks++; if (rotation !== 2'd3 || blk_voff !== pk(0, 1, -1, 0) || blk_hoff !== pk(1, 1, 0, 0)) begin
         $display("FAIL illegal_spawn got r%0d %h %h want r3 %h %h", rotation, blk_voff, blk_hoff, pk(0, 1, -1, 0), pk(1, 1, 0, 0)); errors++; end
      active = 1'b0;
      #1;
      checks++; if (blk_voff !== '0 || blk_hoff !== '0 || rotation !== 2'd0) begin
         $display("FAIL inactive_zero got %h %h r%0d want 0 0 r0", blk_voff, blk_hoff, rotation); errors++; end
      rot_req = 1'b1;
      step();
      rot_req = 1'b0;
      active = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || rotation !== 2'd3 || blk_voff !== pk(0, 1, -1, 0)) begin
         $display("FAIL reactive got busy %b r%0d %h want 0 r3 %h", busy, rotation, blk_voff, pk(0, 1, -1, 0)); errors++; end
      rot_req = 1'b1; rot_dir = 1'b0;
      step();
      rot_req = 1'b0;
      active = 1'b0;
      step();
      active = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || rot_done !== 1'b0 || rotation !== 2'd3) begin
         $display("FAIL inactive_abort got busy %b d %b r%0d want 0 0 r3", busy, rot_done, rotation); errors++; end
   endtask

   task automatic test_o_spin();
      do_spawn(3'd1);
      for (int r = 0; r < 4; r++) begin
         rot_req = 1'b1; rot_dir = 1'b0;
         step();
         rot_req = 1'b0;
         chk_done = 1'b1; chk_ok = 1'b1;
         step();
         chk_done = 1'b0; chk_ok = 1'b0;
         checks++; if (rot_done !== 1'b1 || rotation !== 2'((r + 1) % 4) || blk_voff !== pk(1, 1, 0, 0) || blk_hoff !== pk(1, 0, 1, 0)) begin
            $display("FAIL o_spin%0d got d %b r%0d %h %h want 1 r%0d %h %h", r, rot_done, rotation, blk_voff, blk_hoff, (r + 1) % 4, pk(1, 1, 0, 0), pk(1, 0, 1, 0)); errors++; end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_spawn_l();
      test_rotate_t();
      test_kicks_i();
      test_exhaust();
      test_spawn_abort();
      test_ccw_s();
      test_illegal_active();
      test_o_spin();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
